el2_dccm_init_scrubber: RTL and testbench
=========================================

Name: el2_dccm_init_scrubber

Overview:
Upstream master on the DCCM port of the LSU DCCM memory wrapper.
- After reset, on request, it writes ECC-correct zero to every DCCM word.
- It then scrubs in the background. It reads word pairs periodically, SECDED-checks them, writes back corrected data on single-bit errors, and logs double-bit errors.
- It issues accesses only in cycles the LSU leaves the port idle. An external mux selects its port signals when own_port=1.

Parameters:
DCCM_SIZE, 64, DCCM capacity in KB
DCCM_BITS, 16, byte-address width = log2(DCCM_SIZE*1024)
DCCM_DATA_WIDTH, 32, data bits per word
DCCM_FDATA_WIDTH, 39, data+ECC bits per word
SCRUB_INTERVAL, 1024, idle cycles between scrub reads (>=2)
CNT_W, 16, width of the single-bit correction counter

Ports:
clk  in  1  clock; single clock domain
rst  in  1  reset; synchronous, active-high
start_init  in  1  one-cycle pulse; begin the full-array zero-init
scrub_en  in  1  level; enables background scrub once init is done
lsu_dccm_busy  in  1  LSU uses the DCCM port this cycle; block must not access it
own_port  out  1  block drives the DCCM port this cycle
dccm_wren  out  1  write enable (lo+hi)
dccm_rden  out  1  read enable (lo+hi)
dccm_wr_addr_lo  out  DCCM_BITS  write byte address, even word
dccm_wr_addr_hi  out  DCCM_BITS  write byte address, odd word (lo|4)
dccm_rd_addr_lo  out  DCCM_BITS  read byte address, even word
dccm_rd_addr_hi  out  DCCM_BITS  read byte address, odd word
dccm_wr_data_lo  out  DCCM_FDATA_WIDTH  {ecc,data} even word
dccm_wr_data_hi  out  DCCM_FDATA_WIDTH  {ecc,data} odd word
dccm_rd_data_lo  in  DCCM_FDATA_WIDTH  read data, 1 cycle after dccm_rden
dccm_rd_data_hi  in  DCCM_FDATA_WIDTH  read data, odd word
init_done  out  1  sticky; array fully initialised
busy  out  1  state != IDLE/SCRUB_WAIT
sb_err_cnt  out  CNT_W  saturating count of corrected words
db_err  out  1  sticky double-bit error flag
db_err_addr  out  DCCM_BITS  byte address of the first double-bit error

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE; all outputs 0; pair pointer=0; interval counter=0.
  - Mid-operation reset aborts immediately. No further port access occurs. init_done clears.
- Pair pointer P:
  - Counts word pairs 0..NPAIRS-1, where NPAIRS = DCCM_SIZE*1024/8.
  - lo addr = {P,3'b000}; hi addr = {P,3'b100}.
  - Wraps to 0 after NPAIRS-1.
- Port rule:
  - dccm_wren/dccm_rden are asserted only when lsu_dccm_busy=0 that cycle.
  - own_port equals (dccm_wren|dccm_rden).
  - wren and rden are never both 1.
- States:
  - IDLE:
    - start_init -> INIT with P=0.
    - Else, if init_done & scrub_en -> SCRUB_WAIT.
  - INIT:
    - Each non-busy cycle writes encode(0) to both words at P, then P++.
    - After the write of P=NPAIRS-1: init_done=1, P=0, go to IDLE.
    - Busy cycles stall without advancing P.
    - start_init while in INIT is ignored.
  - SCRUB_WAIT:
    - Counts SCRUB_INTERVAL cycles, then -> SCRUB_RD.
    - scrub_en=0 -> IDLE (counter cleared).
    - start_init in any scrub state -> INIT with P=0, init_done cleared.
  - SCRUB_RD:
    - First non-busy cycle asserts rden at P -> SCRUB_CHK.
  - SCRUB_CHK:
    - Registers rd_data_lo/hi and decodes both words.
    - No error on either word: P++ -> SCRUB_WAIT.
    - Double-bit error on either word:
      - Set db_err.
      - Capture db_err_addr (lo addr if lo failed, else hi) only if db_err was 0.
      - No write-back; P++ -> SCRUB_WAIT.
    - Otherwise (single-bit error on at least one word, no double-bit error) -> SCRUB_WB.
  - SCRUB_WB:
    - If lsu_dccm_busy=1 in this cycle, the LSU may have written the pair. Drop the write-back, leave P and the count unchanged, and retry via SCRUB_RD.
    - Else write the corrected lo and hi words, re-encoded, at P.
    - sb_err_cnt += number of corrected words (1 or 2), saturating at all-ones.
    - P++ -> SCRUB_WAIT.
- ECC: VeeR 39-bit SECDED (6 Hamming + overall parity). An error in the ECC bits only still counts as single-bit and is rewritten.
- Init latency with no stalls: start_init at cycle 0; writes in cycles 1..NPAIRS; init_done=1 from cycle NPAIRS+1.

Decomposition:
- el2_pkg adds:
  - enum el2_dccm_scrub_state_e {IDLE, INIT, SCRUB_WAIT, SCRUB_RD, SCRUB_CHK, SCRUB_WB}.
  - Constant DCCM_ECC_W=7.
- Combinational sub-module el2_dccm_secded39, instantiated twice:
  - Encoder: data -> {ecc,data}.
  - Decoder: fdata -> corrected data, sb_err, db_err.
- The top holds the FSM, pointer, interval counter and logging registers.

Test Plan:
- DCCM_SIZE=4 (NPAIRS=512), lsu_dccm_busy=0, start_init pulse -> 512 consecutive wren cycles, addrs 0x000/0x004 .. 0xFF8/0xFFC, data 39'h0; init_done=1 at cycle 513.
- Init with lsu_dccm_busy=1 on every 3rd cycle -> no wren in busy cycles, each address written exactly once, init_done at cycle 768.
- After init, flip data bit 5 of word 0x010 in the memory model; scrub_en=1, SCRUB_INTERVAL=2 -> write-back to 0x010/0x014 with corrected data; sb_err_cnt=1.
- Flip bits 3 and 9 of word 0x024 -> no write-back; db_err=1, db_err_addr=0x024; a later double-bit error at 0x100 leaves db_err_addr=0x024.
- Single-bit error pending, lsu_dccm_busy=1 in the SCRUB_WB cycle -> write-back dropped, re-read of the same pair, corrected on retry, sb_err_cnt increments once.
- rst asserted mid-INIT at P=100 -> next cycle all outputs 0, no wren; a new start_init restarts at address 0x000.

Source files
------------

// File: rtl/el2_pkg.sv
// rtl/el2_pkg.sv - shared types and SECDED helpers for the DCCM init/scrub engine
// Hamming positions follow the VeeR 39-bit layout: data fills the non-power-of-two positions 3..38.

package el2_pkg;

  localparam int DCCM_ECC_W = 7;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    SCRUB_WAIT,
    SCRUB_RD,
    SCRUB_CHK,
    SCRUB_WB
  } el2_dccm_scrub_state_e;

  // XOR of the Hamming positions of every set data bit; bit k is check bit k.
  function automatic logic [DCCM_ECC_W-2:0] secded39_hamming(input logic [31:0] d);
    logic [DCCM_ECC_W-2:0] h;
    int di;
    h  = '0;
    di = 0;
    for (int p = 1; p < 39; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (d[di[4:0]]) h = h ^ p[5:0];
        di++;
      end
    end
    return h;
  endfunction

  // A syndrome that names a check-bit position (or nothing) leaves the data untouched.
  function automatic logic [31:0] secded39_flip(input logic [31:0] d,
                                                input logic [DCCM_ECC_W-2:0] syn);
    logic [31:0] c;
    int di;
    c  = d;
    di = 0;
    for (int p = 1; p < 39; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (syn == p[5:0]) c[di[4:0]] = ~c[di[4:0]];
        di++;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/el2_dccm_secded39.sv
// rtl/el2_dccm_secded39.sv - combinational 39-bit SECDED encoder and decoder for one DCCM word
// The overall parity bit decides single vs. double: odd parity is always treated as correctable.

module el2_dccm_secded39
  import el2_pkg::*;
(
  input  logic [31:0]            enc_data_i,
  output logic [38:0]            enc_fdata_o,
  input  logic [38:0]            dec_fdata_i,
  output logic [31:0]            dec_data_o,
  output logic                   dec_sb_err_o,
  output logic                   dec_db_err_o
);

  logic [DCCM_ECC_W-2:0] enc_ham;
  logic [DCCM_ECC_W-2:0] dec_syn;
  logic                  dec_par;

  assign enc_ham     = secded39_hamming(enc_data_i);
  assign enc_fdata_o = {^{enc_ham, enc_data_i}, enc_ham, enc_data_i};

  assign dec_syn = secded39_hamming(dec_fdata_i[31:0]) ^ dec_fdata_i[37:32];
  assign dec_par = ^dec_fdata_i;

  assign dec_sb_err_o = dec_par;
  assign dec_db_err_o = ~dec_par & (dec_syn != '0);
  assign dec_data_o   = dec_par ? secded39_flip(dec_fdata_i[31:0], dec_syn) : dec_fdata_i[31:0];

endmodule

// File: rtl/el2_dccm_init_scrubber.sv
// rtl/el2_dccm_init_scrubber.sv - DCCM zero-init and background SECDED scrub master
// Port strobes are combinational on lsu_dccm_busy so the LSU always wins the shared port.

module el2_dccm_init_scrubber
  import el2_pkg::*;
#(
  parameter int DCCM_SIZE        = 64,
  parameter int DCCM_BITS        = 16,
  parameter int DCCM_DATA_WIDTH  = 32,
  parameter int DCCM_FDATA_WIDTH = 39,
  parameter int SCRUB_INTERVAL   = 1024,
  parameter int CNT_W            = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_init,
  input  logic                        scrub_en,
  input  logic                        lsu_dccm_busy,
  output logic                        own_port,
  output logic                        dccm_wren,
  output logic                        dccm_rden,
  output logic [DCCM_BITS-1:0]        dccm_wr_addr_lo,
  output logic [DCCM_BITS-1:0]        dccm_wr_addr_hi,
  output logic [DCCM_BITS-1:0]        dccm_rd_addr_lo,
  output logic [DCCM_BITS-1:0]        dccm_rd_addr_hi,
  output logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data_lo,
  output logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data_hi,
  input  logic [DCCM_FDATA_WIDTH-1:0] dccm_rd_data_lo,
  input  logic [DCCM_FDATA_WIDTH-1:0] dccm_rd_data_hi,
  output logic                        init_done,
  output logic                        busy,
  output logic [CNT_W-1:0]            sb_err_cnt,
  output logic                        db_err,
  output logic [DCCM_BITS-1:0]        db_err_addr
);

  localparam int PW     = DCCM_BITS - 3;
  localparam int NPAIRS = DCCM_SIZE * 1024 / 8;
  localparam int IW     = $clog2(SCRUB_INTERVAL);

  el2_dccm_scrub_state_e state_q;
  logic [PW-1:0]              ptr_q;
  logic [IW-1:0]              ival_q;
  logic                       init_done_q;
  logic                       db_err_q;
  logic [DCCM_BITS-1:0]       db_err_addr_q;
  logic [CNT_W-1:0]           sb_cnt_q;
  logic [DCCM_DATA_WIDTH-1:0] corr_lo_q;
  logic [DCCM_DATA_WIDTH-1:0] corr_hi_q;
  logic [1:0]                 sb_num_q;

  logic [DCCM_BITS-1:0]        addr_lo;
  logic [DCCM_BITS-1:0]        addr_hi;
  logic [DCCM_FDATA_WIDTH-1:0] enc_lo;
  logic [DCCM_FDATA_WIDTH-1:0] enc_hi;
  logic [DCCM_DATA_WIDTH-1:0]  dec_lo_data;
  logic [DCCM_DATA_WIDTH-1:0]  dec_hi_data;
  logic                        dec_lo_sb;
  logic                        dec_hi_sb;
  logic                        dec_lo_db;
  logic                        dec_hi_db;
  logic                        wr_go;
  logic                        rd_go;
  logic                        scrub_state;
  logic [CNT_W:0]              sb_sum_d;

  el2_dccm_secded39 u_secded_lo (
    .enc_data_i   (corr_lo_q),
    .enc_fdata_o  (enc_lo),
    .dec_fdata_i  (dccm_rd_data_lo),
    .dec_data_o   (dec_lo_data),
    .dec_sb_err_o (dec_lo_sb),
    .dec_db_err_o (dec_lo_db)
  );

  el2_dccm_secded39 u_secded_hi (
    .enc_data_i   (corr_hi_q),
    .enc_fdata_o  (enc_hi),
    .dec_fdata_i  (dccm_rd_data_hi),
    .dec_data_o   (dec_hi_data),
    .dec_sb_err_o (dec_hi_sb),
    .dec_db_err_o (dec_hi_db)
  );

  assign addr_lo = {ptr_q, 3'b000};
  assign addr_hi = {ptr_q, 3'b100};

  // rst gating makes an abort take effect in the very cycle it is asserted.
  assign wr_go = ~rst & ~lsu_dccm_busy & ((state_q == INIT) | (state_q == SCRUB_WB));
  assign rd_go = ~rst & ~lsu_dccm_busy & (state_q == SCRUB_RD);

  assign dccm_wren       = wr_go;
  assign dccm_rden       = rd_go;
  assign own_port        = wr_go | rd_go;
  assign dccm_wr_addr_lo = wr_go ? addr_lo : '0;
  assign dccm_wr_addr_hi = wr_go ? addr_hi : '0;
  assign dccm_rd_addr_lo = rd_go ? addr_lo : '0;
  assign dccm_rd_addr_hi = rd_go ? addr_hi : '0;
  // Zero-init words are encode(0), which is all zeros in this code.
  assign dccm_wr_data_lo = (wr_go && state_q == SCRUB_WB) ? enc_lo : '0;
  assign dccm_wr_data_hi = (wr_go && state_q == SCRUB_WB) ? enc_hi : '0;

  assign scrub_state = (state_q == SCRUB_WAIT) | (state_q == SCRUB_RD) |
                       (state_q == SCRUB_CHK)  | (state_q == SCRUB_WB);
  assign sb_sum_d    = {1'b0, sb_cnt_q} + {{(CNT_W-1){1'b0}}, sb_num_q};

  assign init_done   = init_done_q;
  assign busy        = (state_q != IDLE) & (state_q != SCRUB_WAIT);
  assign sb_err_cnt  = sb_cnt_q;
  assign db_err      = db_err_q;
  assign db_err_addr = db_err_addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      ival_q        <= '0;
      init_done_q   <= 1'b0;
      db_err_q      <= 1'b0;
      db_err_addr_q <= '0;
      sb_cnt_q      <= '0;
      corr_lo_q     <= '0;
      corr_hi_q     <= '0;
      sb_num_q      <= '0;
    end else if (start_init && scrub_state) begin
      state_q     <= INIT;
      ptr_q       <= '0;
      ival_q      <= '0;
      init_done_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_init) begin
            state_q <= INIT;
            ptr_q   <= '0;
          end else if (init_done_q && scrub_en) begin
            state_q <= SCRUB_WAIT;
            ival_q  <= '0;
          end
        end
        INIT: begin
          if (!lsu_dccm_busy) begin
            if (ptr_q == PW'(NPAIRS - 1)) begin
              ptr_q       <= '0;
              init_done_q <= 1'b1;
              state_q     <= IDLE;
            end else begin
              ptr_q <= ptr_q + PW'(1);
            end
          end
        end
        SCRUB_WAIT: begin
          if (!scrub_en) begin
            state_q <= IDLE;
            ival_q  <= '0;
          end else if (ival_q == IW'(SCRUB_INTERVAL - 1)) begin
            state_q <= SCRUB_RD;
            ival_q  <= '0;
          end else begin
            ival_q <= ival_q + IW'(1);
          end
        end
        SCRUB_RD: begin
          if (!lsu_dccm_busy) state_q <= SCRUB_CHK;
        end
        SCRUB_CHK: begin
          corr_lo_q <= dec_lo_data;
          corr_hi_q <= dec_hi_data;
          sb_num_q  <= {1'b0, dec_lo_sb} + {1'b0, dec_hi_sb};
          if (dec_lo_db || dec_hi_db) begin
            db_err_q <= 1'b1;
            if (!db_err_q) db_err_addr_q <= dec_lo_db ? addr_lo : addr_hi;
            ptr_q   <= ptr_q + PW'(1);
            state_q <= SCRUB_WAIT;
          end else if (dec_lo_sb || dec_hi_sb) begin
            state_q <= SCRUB_WB;
          end else begin
            ptr_q   <= ptr_q + PW'(1);
            state_q <= SCRUB_WAIT;
          end
        end
        SCRUB_WB: begin
          // A busy cycle means the LSU may have just rewritten this pair: re-read it.
          if (lsu_dccm_busy) begin
            state_q <= SCRUB_RD;
          end else begin
            sb_cnt_q <= sb_sum_d[CNT_W] ? '1 : sb_sum_d[CNT_W-1:0];
            ptr_q    <= ptr_q + PW'(1);
            state_q  <= SCRUB_WAIT;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_el2_dccm_init_scrubber.sv
// tb/tb_el2_dccm_init_scrubber.sv - directed bench for the DCCM init/scrub engine
// Uses a 4 KB array (512 pairs) and a 2-cycle scrub interval.

`timescale 1ns/1ps

module tb_el2_dccm_init_scrubber;

  localparam int AW = 12;
  localparam int FW = 39;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_init = 1'b0;
  logic          scrub_en = 1'b0;
  logic          lsu_dccm_busy = 1'b0;
  logic          own_port, dccm_wren, dccm_rden;
  logic [AW-1:0] dccm_wr_addr_lo, dccm_wr_addr_hi, dccm_rd_addr_lo, dccm_rd_addr_hi;
  logic [FW-1:0] dccm_wr_data_lo, dccm_wr_data_hi;
  logic [FW-1:0] dccm_rd_data_lo, dccm_rd_data_hi;
  logic          init_done, busy, db_err;
  logic [15:0]   sb_err_cnt;
  logic [AW-1:0] db_err_addr;

  always #5 clk = ~clk;

  el2_dccm_init_scrubber #(
    .DCCM_SIZE(4), .DCCM_BITS(AW), .DCCM_DATA_WIDTH(32), .DCCM_FDATA_WIDTH(FW),
    .SCRUB_INTERVAL(2), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .start_init(start_init), .scrub_en(scrub_en),
    .lsu_dccm_busy(lsu_dccm_busy), .own_port(own_port),
    .dccm_wren(dccm_wren), .dccm_rden(dccm_rden),
    .dccm_wr_addr_lo(dccm_wr_addr_lo), .dccm_wr_addr_hi(dccm_wr_addr_hi),
    .dccm_rd_addr_lo(dccm_rd_addr_lo), .dccm_rd_addr_hi(dccm_rd_addr_hi),
    .dccm_wr_data_lo(dccm_wr_data_lo), .dccm_wr_data_hi(dccm_wr_data_hi),
    .dccm_rd_data_lo(dccm_rd_data_lo), .dccm_rd_data_hi(dccm_rd_data_hi),
    .init_done(init_done), .busy(busy), .sb_err_cnt(sb_err_cnt),
    .db_err(db_err), .db_err_addr(db_err_addr)
  );

  logic [FW-1:0] mem [1024];

  always @(posedge clk) begin
    if (dccm_wren) begin
      mem[dccm_wr_addr_lo[11:2]] = dccm_wr_data_lo;
      mem[dccm_wr_addr_hi[11:2]] = dccm_wr_data_hi;
    end
    if (dccm_rden) begin
      dccm_rd_data_lo <= mem[dccm_rd_addr_lo[11:2]];
      dccm_rd_data_hi <= mem[dccm_rd_addr_hi[11:2]];
    end
  end

  typedef struct {
    logic [AW-1:0] alo;
    logic [AW-1:0] ahi;
    logic [FW-1:0] dlo;
    logic [FW-1:0] dhi;
  } wr_t;

  wr_t           wr_q[$];
  logic [AW-1:0] rd_q[$];
  int            viol = 0;

  always @(negedge clk) begin
    if (dccm_wren && lsu_dccm_busy) viol++;
    if (dccm_wren && dccm_rden) viol++;
    if (own_port !== (dccm_wren | dccm_rden)) viol++;
    if (dccm_wren) wr_q.push_back('{dccm_wr_addr_lo, dccm_wr_addr_hi, dccm_wr_data_lo, dccm_wr_data_hi});
    if (dccm_rden) rd_q.push_back(dccm_rd_addr_lo);
  end

  int n_vec  = 0;
  int n_miss = 0;

  task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic prefill();
    for (int i = 0; i < 1024; i++) mem[i] = {7'($urandom), 32'($urandom)};
  endtask

  // Pulse start_init in cycle 0 and return the first cycle init_done reads 1 (-1 on timeout).
  task automatic run_init(input int busy_mod, output int done_cyc);
    wr_q.delete();
    start_init = 1'b1;
    step();
    start_init = 1'b0;
    done_cyc = -1;
    for (int n = 1; n < 2000; n++) begin
      lsu_dccm_busy = (busy_mod != 0) && (n % busy_mod == 0);
      #1;
      if (init_done) begin
        done_cyc = n;
        break;
      end
      step();
    end
    lsu_dccm_busy = 1'b0;
  endtask

  function automatic int bad_init_writes();
    int bad = 0;
    for (int i = 0; i < wr_q.size(); i++) begin
      if (wr_q[i].alo != AW'(i * 8) || wr_q[i].ahi != AW'(i * 8 + 4) ||
          wr_q[i].dlo != '0 || wr_q[i].dhi != '0) bad++;
    end
    return bad;
  endfunction

  function automatic int count_reads(input logic [AW-1:0] a);
    int c = 0;
    foreach (rd_q[i]) if (rd_q[i] == a) c++;
    return c;
  endfunction

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int done_cyc;
    int nz;
    int arm;
    bit fired;

    reset_dut();
    #1;
    expect_eq("rst_own_port", own_port, 0);
    expect_eq("rst_wren", dccm_wren, 0);
    expect_eq("rst_rden", dccm_rden, 0);
    expect_eq("rst_init_done", init_done, 0);
    expect_eq("rst_busy", busy, 0);
    expect_eq("rst_sb_cnt", sb_err_cnt, 0);
    expect_eq("rst_db_err", db_err, 0);
    expect_eq("rst_db_addr", db_err_addr, 0);

    // Unstalled init
    prefill();
    run_init(0, done_cyc);
    expect_eq("init_done_cycle", done_cyc, 513);
    expect_eq("init_write_count", wr_q.size(), 512);
    expect_eq("init_write_seq", bad_init_writes(), 0);
    nz = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] != '0) nz++;
    expect_eq("init_mem_zero", nz, 0);

    // Init with the LSU taking every third cycle
    reset_dut();
    prefill();
    run_init(3, done_cyc);
    expect_eq("stall_done_cycle", done_cyc, 768);
    expect_eq("stall_write_count", wr_q.size(), 512);
    expect_eq("stall_write_seq", bad_init_writes(), 0);

    // Scrub: data-bit error at 0x010, check-bit error at 0x018, double errors at 0x024 and 0x100
    mem[12'h010 >> 2] = mem[12'h010 >> 2] ^ 39'h20;
    mem[12'h018 >> 2] = 39'h47_0000_0001;
    mem[12'h024 >> 2] = mem[12'h024 >> 2] ^ 39'h208;
    mem[12'h100 >> 2] = mem[12'h100 >> 2] ^ 39'h3;
    wr_q.delete();
    rd_q.delete();
    scrub_en = 1'b1;
    repeat (200) step();
    expect_eq("scrub_wb_count", wr_q.size(), 2);
    if (wr_q.size() >= 2) begin
      expect_eq("wb0_addr_lo", wr_q[0].alo, 12'h010);
      expect_eq("wb0_addr_hi", wr_q[0].ahi, 12'h014);
      expect_eq("wb0_data_lo", wr_q[0].dlo, 39'h0);
      expect_eq("wb0_data_hi", wr_q[0].dhi, 39'h0);
      expect_eq("wb1_addr_lo", wr_q[1].alo, 12'h018);
      expect_eq("wb1_data_lo", wr_q[1].dlo, 39'h43_0000_0001);
      expect_eq("wb1_data_hi", wr_q[1].dhi, 39'h0);
    end
    expect_eq("scrub_sb_cnt", sb_err_cnt, 2);
    expect_eq("scrub_db_err", db_err, 1);
    expect_eq("scrub_db_addr", db_err_addr, 12'h024);
    expect_eq("scrub_read_0x100", count_reads(12'h100), 1);
    expect_eq("mem_0x010_fixed", mem[12'h010 >> 2], 39'h0);
    expect_eq("mem_0x018_fixed", mem[12'h018 >> 2], 39'h43_0000_0001);
    expect_eq("mem_0x024_untouched", mem[12'h024 >> 2], 39'h208);

    // Write-back collides with an LSU cycle and must be retried
    scrub_en = 1'b0;
    reset_dut();
    run_init(0, done_cyc);
    expect_eq("retry_init_cycle", done_cyc, 513);
    mem[12'h00C >> 2] = mem[12'h00C >> 2] ^ 39'h1;
    wr_q.delete();
    rd_q.delete();
    scrub_en = 1'b1;
    arm = -1;
    fired = 1'b0;
    for (int n = 1; n <= 80; n++) begin
      step();
      lsu_dccm_busy = (n == arm);
      #1;
      if (dccm_rden && dccm_rd_addr_lo == 12'h008 && !fired) begin
        arm = n + 2;
        fired = 1'b1;
      end
    end
    lsu_dccm_busy = 1'b0;
    expect_eq("retry_reads_0x008", count_reads(12'h008), 2);
    expect_eq("retry_wb_count", wr_q.size(), 1);
    if (wr_q.size() >= 1) begin
      expect_eq("retry_wb_addr_lo", wr_q[0].alo, 12'h008);
      expect_eq("retry_wb_data_hi", wr_q[0].dhi, 39'h0);
    end
    expect_eq("retry_sb_cnt", sb_err_cnt, 1);
    expect_eq("retry_mem_0x00c", mem[12'h00C >> 2], 39'h0);

    // Reset in the middle of an init pass
    scrub_en = 1'b0;
    reset_dut();
    run_init(0, done_cyc);
    step();
    expect_eq("midrst_pre_done", init_done, 1);
    wr_q.delete();
    start_init = 1'b1;
    step();
    start_init = 1'b0;
    repeat (100) step();
    expect_eq("midrst_writes_before", wr_q.size(), 100);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    expect_eq("midrst_wren", dccm_wren, 0);
    expect_eq("midrst_own_port", own_port, 0);
    expect_eq("midrst_init_done", init_done, 0);
    expect_eq("midrst_busy", busy, 0);
    expect_eq("midrst_wr_addr_hi", dccm_wr_addr_hi, 0);
    wr_q.delete();
    repeat (5) step();
    expect_eq("midrst_no_writes", wr_q.size(), 0);
    start_init = 1'b1;
    step();
    start_init = 1'b0;
    #1;
    expect_eq("restart_wren", dccm_wren, 1);
    expect_eq("restart_addr_lo", dccm_wr_addr_lo, 12'h000);
    expect_eq("restart_addr_hi", dccm_wr_addr_hi, 12'h004);

    expect_eq("port_rule_violations", viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
